pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Fetch stage of the accumulator datapath, directly upstream of connected_control_memory.
//  Owns the 10-bit program counter and sequences FETCH -> LOAD -> EXEC per instruction.
//  Drives PC to instruction memory, latches the returned 16-bit word into an instruction
//  register, holds it for decode/execute, then advances PC by +1 or by a taken-branch offset.
// PARAMETERS
//  PC_W      10      program counter width; PC wraps modulo 2**PC_W
//  INSTR_W   16      instruction word width
//  OFF_W     8       branch offset width, two's complement, in instruction words
//  RESET_PC  'h000   PC value loaded on reset
// PORTS
//  clk            in   1        clock; all state changes on posedge
//  rst_n          in   1        asynchronous, active-low reset
//  start          in   1        begin fetching from current PC; sampled in IDLE only
//  halt           in   1        stop after current instruction retires
//  instr_in       in   INSTR_W  instruction memory read data; valid the cycle after fetch_en
//  exec_done      in   1        execute stage finished current instruction (1-cycle pulse)
//  branch_taken   in   1        Branch AND condition true; sampled with exec_done only
//  branch_offset  in   OFF_W    signed word offset, relative to current PC
//  pc             out  PC_W     current program counter, to instruction memory
//  fetch_en       out  1        instruction memory read strobe
//  ir             out  INSTR_W  latched instruction word, to control decode
//  ir_valid       out  1        ir holds a live instruction (high throughout EXEC)
//  busy           out  1        state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, ir=0, ir_valid=0, fetch_en=0, busy=0, state=IDLE.
//   rst_n asserted mid-instruction aborts it immediately; no PC update, ir cleared.
//  States: IDLE, FETCH, LOAD, EXEC (2-bit encoding from shared package).
//  IDLE : outputs quiet. start=1 -> FETCH. halt is ignored in IDLE.
//  FETCH: fetch_en=1 for exactly this cycle; pc stable. -> LOAD unconditionally.
//  LOAD : fetch_en=0; ir <= instr_in at end of cycle; ir_valid rises with EXEC. -> EXEC.
//  EXEC : ir, pc held; ir_valid=1. Wait for exec_done.
//   exec_done=1: pc <= branch_taken ? pc + sext(branch_offset) : pc + 1 (both mod 2**PC_W);
//   ir_valid drops next cycle; next state = halt_pending ? IDLE : FETCH.
//  halt: sets halt_pending in any non-IDLE state; cleared on entering IDLE.
//   halt asserted together with exec_done -> PC still updates, then IDLE.
//  Latency: start sampled at edge N -> fetch_en high in cycle N+1 -> ir_valid high from N+3.
//   Minimum 3 cycles/instruction (exec_done on first EXEC cycle).
//  Wrap: pc=2**PC_W-1 with +1 -> 0. Backward offsets wrap below 0 the same way.
//  branch_taken/branch_offset ignored unless exec_done=1 in EXEC.
//  exec_done outside EXEC is ignored (no PC change, no state change).
//  start re-asserted while busy: ignored.
// STRUCTURE
//  Shared package accum_pkg: state encoding (ST_IDLE..ST_EXEC), PC_W, INSTR_W, OFF_W defaults.
//  One sub-module: pc_next_calc (combinational: pc, branch_taken, branch_offset -> pc_next,
//   sign-extension plus PC_W-bit add). Remaining FSM, PC and IR registers live in this module.
// TESTING
//  1 Reset: hold rst_n=0, then release -> pc=0x000, ir=0, ir_valid=0, busy=0, fetch_en=0.
//  2 Sequential: mem[0x004]=0x1234, pc preset via RESET_PC=0x004; pulse start, exec_done
//    on each first EXEC cycle -> fetch_en pulses every 3 cycles, ir=0x1234, pc 0x004->0x005->0x006.
//  3 Branch: at pc=0x007, exec_done=1, branch_taken=1, offset=8'hFC (-4) -> pc=0x003;
//    with offset=8'h05 -> pc=0x00C; with branch_taken=0 -> pc=0x008.
//  4 Wrap: RESET_PC=0x3FF, one instruction, no branch -> pc=0x000; at pc=0x001, offset=-2 -> 0x3FF.
//  5 Halt: halt pulsed during LOAD at pc=0x010 -> instruction retires, pc=0x011, busy=0,
//    no further fetch_en; halt with exec_done in the same cycle gives identical result.
//  6 Async reset mid-EXEC at pc=0x020 with ir=0xABCD -> same cycle pc=RESET_PC, ir=0,
//    ir_valid=0, state IDLE; later exec_done pulses cause no change.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator datapath: fetch FSM encoding and default widths.
package accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_OFF_W   = 8;

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_calc.sv
// Next-PC arithmetic: sequential +1 or sign-extended branch offset, both modulo 2**PC_W.
module pc_next_calc #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_offset,
    output logic [PC_W-1:0]  pc_next
);

    logic [PC_W-1:0] offExt;

    // A size cast of a signed operand sign-extends, so negative offsets wrap naturally.
    assign offExt  = PC_W'($signed(branch_offset));
    assign pc_next = branch_taken ? (pc + offExt) : (pc + PC_W'(1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch stage: owns the PC, sequences FETCH -> LOAD -> EXEC and holds the instruction register.
module pc_fetch_sequencer
    import accum_pkg::*;
#(
    parameter int                PC_W     = DEF_PC_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                OFF_W    = DEF_OFF_W,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [OFF_W-1:0]   branch_offset,
    output logic [PC_W-1:0]    pc,
    output logic               fetch_en,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               busy,
    output state_t             dbgState
);

    // Handshakes: fetch_en is a one-cycle read strobe and instr_in is taken exactly one
    // cycle later with no back-pressure; ir_valid acts as "valid" towards execute and
    // exec_done is the one-cycle "ready/accept" that retires the instruction held in ir.

    state_t          state;
    logic            haltPending;
    logic [PC_W-1:0] pcNext;

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) uPcNext (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc_next       (pcNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            ir_valid    <= 1'b0;
            fetch_en    <= 1'b0;
            busy        <= 1'b0;
            haltPending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        fetch_en <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state    <= ST_LOAD;
                    fetch_en <= 1'b0;
                    if (halt) haltPending <= 1'b1;
                end
                ST_LOAD: begin
                    state    <= ST_EXEC;
                    ir       <= instr_in;
                    ir_valid <= 1'b1;
                    if (halt) haltPending <= 1'b1;
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc       <= pcNext;
                        ir_valid <= 1'b0;
                        // A halt arriving with exec_done still lets this instruction retire.
                        if (haltPending || halt) begin
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            haltPending <= 1'b0;
                        end else begin
                            state    <= ST_FETCH;
                            fetch_en <= 1'b1;
                        end
                    end else if (halt) begin
                        haltPending <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer against an instruction-level reference model.
module tb_pc_fetch_sequencer;
    import accum_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic [15:0] instr_in;
    logic        exec_done;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic [9:0]  pc;
    logic        fetch_en;
    logic [15:0] ir;
    logic        ir_valid;
    logic        busy;
    state_t      dbgState;

    int          checks   = 0;
    int          failures = 0;
    int          modelPc;
    logic [15:0] mem [1024];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .PC_W     (10),
        .INSTR_W  (16),
        .OFF_W    (8),
        .RESET_PC (10'h000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt          (halt),
        .instr_in      (instr_in),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc            (pc),
        .fetch_en      (fetch_en),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .busy          (busy),
        .dbgState      (dbgState)
    );

    // Instruction memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fetch_en) instr_in <= mem[pc];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge of a FETCH cycle; retires one instruction.
    // haltAt: 0 none, 1 halt during LOAD, 2 halt together with exec_done.
    task automatic exec_instr(input bit taken, input int off, input int waitCyc, input int haltAt);
        logic [15:0] expIr;
        int          stepAmt;
        check_eq("fetch_en_fetch", 32'(fetch_en), 32'd1);
        check_eq("pc_fetch", 32'(pc), 32'(modelPc));
        check_eq("busy_fetch", 32'(busy), 32'd1);
        exp_q.push_back(mem[modelPc]);
        @(negedge clk);
        check_eq("fetch_en_load", 32'(fetch_en), 32'd0);
        check_eq("ir_valid_load", 32'(ir_valid), 32'd0);
        if (haltAt == 1) halt = 1'b1;
        @(negedge clk);
        halt  = 1'b0;
        expIr = exp_q.pop_front();
        check_eq("ir_exec", 32'(ir), 32'(expIr));
        check_eq("ir_valid_exec", 32'(ir_valid), 32'd1);
        check_eq("state_exec", 32'(dbgState), 32'(ST_EXEC));
        for (int i = 0; i < waitCyc; i++) begin
            branch_taken  = 1'($urandom_range(0, 1));
            branch_offset = 8'($urandom_range(0, 255));
            start         = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("pc_hold", 32'(pc), 32'(modelPc));
            check_eq("ir_valid_hold", 32'(ir_valid), 32'd1);
        end
        start         = 1'b0;
        exec_done     = 1'b1;
        branch_taken  = taken;
        branch_offset = 8'(off);
        halt          = (haltAt == 2);
        @(negedge clk);
        exec_done    = 1'b0;
        halt         = 1'b0;
        branch_taken = 1'b0;
        stepAmt = taken ? off : 1;
        modelPc = (modelPc + stepAmt) & 1023;
        check_eq("pc_retire", 32'(pc), 32'(modelPc));
        check_eq("ir_valid_retire", 32'(ir_valid), 32'd0);
        if (haltAt != 0) begin
            check_eq("busy_halt", 32'(busy), 32'd0);
            check_eq("fetch_en_halt", 32'(fetch_en), 32'd0);
            check_eq("state_halt", 32'(dbgState), 32'(ST_IDLE));
        end else begin
            check_eq("fetch_en_next", 32'(fetch_en), 32'd1);
        end
    endtask

    task automatic goto_pc(input int target);
        int d;
        for (int n = 0; n < 20 && modelPc != target; n++) begin
            d = (target - modelPc) & 1023;
            if (d >= 512) d = d - 1024;
            if (d > 100) d = 100;
            if (d < -100) d = -100;
            exec_instr(1'b1, d, 0, 0);
        end
    endtask

    task automatic idle_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            exec_done    = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            halt         = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("idle_fetch_en", 32'(fetch_en), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_pc", 32'(pc), 32'(modelPc));
        end
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        halt         = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[4]    = 16'h1234;
        mem[5]    = 16'h1234;
        mem[32]   = 16'hABCD;
        rst_n         = 1'b0;
        start         = 1'b0;
        halt          = 1'b0;
        exec_done     = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 8'h00;
        modelPc       = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_pc", 32'(pc), 32'h000);
        check_eq("rst_ir", 32'(ir), 32'h0);
        check_eq("rst_ir_valid", 32'(ir_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_fetch_en", 32'(fetch_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_state", 32'(dbgState), 32'(ST_IDLE));

        // Sequential fetch from 0x004
        do_start();
        exec_instr(1'b1, 4, 0, 0);
        exec_instr(1'b0, 0, 0, 0);
        exec_instr(1'b0, 0, 0, 0);
        check_eq("seq_pc6", 32'(pc), 32'h006);

        // Branches around 0x007
        exec_instr(1'b1, 1, 0, 0);
        exec_instr(1'b1, -4, 0, 0);
        check_eq("br_back", 32'(pc), 32'h003);
        exec_instr(1'b1, 4, 0, 0);
        exec_instr(1'b1, 5, 1, 0);
        check_eq("br_fwd", 32'(pc), 32'h00C);
        exec_instr(1'b1, -5, 0, 0);
        exec_instr(1'b0, 77, 2, 0);
        check_eq("br_not_taken", 32'(pc), 32'h008);

        // Wrap in both directions
        exec_instr(1'b1, -7, 0, 0);
        exec_instr(1'b1, -2, 0, 0);
        check_eq("wrap_down", 32'(pc), 32'h3FF);
        exec_instr(1'b0, 0, 0, 0);
        check_eq("wrap_up", 32'(pc), 32'h000);

        // Halt during LOAD at 0x010, then halt with exec_done
        exec_instr(1'b1, 16, 0, 0);
        exec_instr(1'b0, 0, 1, 1);
        check_eq("halt_load_pc", 32'(pc), 32'h011);
        idle_quiet(4);
        do_start();
        exec_instr(1'b1, -1, 0, 0);
        exec_instr(1'b0, 0, 0, 2);
        check_eq("halt_done_pc", 32'(pc), 32'h011);
        idle_quiet(3);

        // Randomized instruction stream
        do_start();
        for (int k = 0; k < 25; k++) begin
            exec_instr(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                       int'($urandom_range(0, 3)), (k == 24) ? int'($urandom_range(1, 2)) : 0);
        end
        idle_quiet(2);

        // Async reset in EXEC at 0x020
        do_start();
        goto_pc(32);
        check_eq("pre_rst_pc", 32'(pc), 32'h020);
        exp_q.push_back(mem[modelPc]);
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_ir", 32'(ir), 32'hABCD);
        void'(exp_q.pop_front());
        #2 rst_n = 1'b0;
        #1;
        modelPc = 0;
        check_eq("arst_pc", 32'(pc), 32'h000);
        check_eq("arst_ir", 32'(ir), 32'h0);
        check_eq("arst_ir_valid", 32'(ir_valid), 32'd0);
        check_eq("arst_state", 32'(dbgState), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        idle_quiet(4);
        check_eq("arst_state_after", 32'(dbgState), 32'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
